if_id_pipe: RTL and testbench
=============================

# if_id_pipe

Parametrised IF/ID pipeline stage for the MIPS core, replacing the fixed always-capture IF/ID register. Carries PC and instruction from fetch to decode under a valid/ready handshake, with synchronous flush for branch/exception redirect and zero-word (NOP) output when empty. An optional 2-entry skid mode registers `in_ready` so fetch never sees a combinational path from decode stall.

## Interface
- `PC_WIDTH`, 32, width of PC field
- `INST_WIDTH`, 32, width of instruction field
- `SKID`, 1, 0 = single-entry stage with combinational ready; 1 = two-entry skid buffer with registered ready

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `flush`  in  1  discard all held entries this edge
- `in_valid`  in  1  fetch offers an entry
- `in_ready`  out  1  stage accepts an entry this cycle
- `in_pc`  in  PC_WIDTH  fetch PC
- `in_inst`  in  INST_WIDTH  fetched instruction
- `out_valid`  out  1  decode entry valid
- `out_ready`  in  1  decode consumes entry this cycle
- `out_pc`  out  PC_WIDTH  PC to decode
- `out_inst`  out  INST_WIDTH  instruction to decode
- `occupancy`  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1)

## Operation
- Transfer in: `in_fire = in_valid & in_ready`. Transfer out: `out_fire = out_valid & out_ready`.
- State: EMPTY, ONE, TWO (TWO reachable only when SKID=1). Main register drives outputs; skid register (SKID=1) holds overflow.
- EMPTY: in_fire -> ONE, main <= input.
- ONE: in_fire & out_fire -> ONE, main <= input; in_fire & !out_fire -> TWO, skid <= input (SKID=1); !in_fire & out_fire -> EMPTY; neither -> ONE, hold.
- TWO: in_ready=0; out_fire -> ONE, main <= skid; else hold.
- `in_ready`: SKID=0 -> `(state==EMPTY) | out_ready`; SKID=1 -> `state!=TWO`, decoded from state register only (no path from `out_ready`). Forced 0 while `rst`=0.
- `out_valid` = `state!=EMPTY`. When EMPTY, `out_pc`=0 and `out_inst`=0 (NOP); data registers are cleared on every transition into EMPTY, not merely masked.
- `occupancy` = 0/1/2 for EMPTY/ONE/TWO.
- Order preserved: main always holds the oldest entry; no entry duplicated or reordered.
- Flush: next state EMPTY, main and skid cleared to 0. An entry offered with `in_fire` in the flush cycle is dropped. `out_fire` in the flush cycle still counts as consumed by decode. Flush priority: reset > flush > handshake.

## Timing
- Reset (`rst`=0 at an edge): state EMPTY, `out_valid`=0, `out_pc`=0, `out_inst`=0, `occupancy`=0; `in_ready`=0 during reset, 1 on first cycle after release.
- Reset mid-transfer: any held entries lost; no partial update.
- Latency: entry accepted at edge N appears on outputs in the cycle after edge N (1 cycle), valid until the edge where `out_fire`.
- Throughput: 1 entry/cycle in both modes when `out_ready` is held high.
- SKID=1, decode stalls at cycle k: at most one further entry accepted (into skid), `in_ready` drops the cycle after the second entry lands; resumes the cycle after first `out_fire`.
- SKID=0: stall propagates to `in_ready` in the same cycle.
- Outputs change only at rising `clk`; no combinational path from `in_*` to `out_*`.

## Test plan
- Reset: hold `rst`=0 two cycles with `in_valid`=1, `in_pc`=0x400 -> `out_valid`=0, `out_pc`=0, `out_inst`=0, `in_ready`=0; after release `in_ready`=1, `occupancy`=0.
- Streaming: `out_ready`=1, PCs 0x0,0x4,0x8,0xC with insts 0x24010001.. on consecutive cycles -> same sequence on outputs one cycle later, `occupancy`=1 throughout, no bubbles.
- Skid fill (SKID=1): load 0x0, drop `out_ready`, offer 0x4, 0x8 -> 0x4 accepted, `occupancy`=2, `in_ready`=0, 0x8 held by fetch; raise `out_ready` -> outputs 0x0, 0x4, 0x8 in order, none lost.
- Stall SKID=0: load 0x0, drop `out_ready` -> `in_ready`=0 same cycle, `out_pc` stays 0x0; raise with `in_valid` for 0x4 -> simultaneous in/out fire, next `out_pc`=0x4.
- Flush: SKID=1 at `occupancy`=2, assert `flush` with `in_valid` for 0x10 -> next cycle EMPTY, `out_inst`=0, 0x10 not delivered; following 0x20 appears one cycle after acceptance.
- Reset while TWO: `rst`=0 one edge -> EMPTY, outputs zero, neither held entry ever appears.

Source files
------------

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: carries PC and instruction from fetch to decode under valid/ready,
// with synchronous flush, NOP output when empty and an optional two-entry skid buffer.
module if_id_pipe #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [INST_WIDTH-1:0] in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e                state_q;
  logic [PC_WIDTH-1:0]   main_pc_q;
  logic [INST_WIDTH-1:0] main_inst_q;
  logic [PC_WIDTH-1:0]   skid_pc_q;
  logic [INST_WIDTH-1:0] skid_inst_q;
  logic                  in_fire;
  logic                  out_fire;

  // In skid mode ready depends only on the state register, cutting the decode-stall path.
  always_comb begin
    if (SKID != 0) begin
      in_ready = rst && (state_q != StTwo);
    end else begin
      in_ready = rst && ((state_q == StEmpty) || out_ready);
    end
  end

  assign out_valid = (state_q != StEmpty);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_pc    = main_pc_q;
  assign out_inst  = main_inst_q;

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StTwo:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_q     <= StEmpty;
      main_pc_q   <= '0;
      main_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_q     <= StOne;
            main_pc_q   <= in_pc;
            main_inst_q <= in_inst;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_pc_q   <= in_pc;
            main_inst_q <= in_inst;
          end else if (in_fire) begin
            // Only reachable in skid mode: without skid, in_ready implies out_fire here.
            state_q     <= StTwo;
            skid_pc_q   <= in_pc;
            skid_inst_q <= in_inst;
          end else if (out_fire) begin
            state_q     <= StEmpty;
            main_pc_q   <= '0;
            main_inst_q <= '0;
          end
        end
        StTwo: begin
          if (out_fire) begin
            state_q     <= StOne;
            main_pc_q   <= skid_pc_q;
            main_inst_q <= skid_inst_q;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
          end
        end
        default: begin
          state_q     <= StEmpty;
          main_pc_q   <= '0;
          main_inst_q <= '0;
          skid_pc_q   <= '0;
          skid_inst_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: SKID=0 and SKID=1 instances share stimulus; each is checked against
// a queue of held entries that also serves as the in-order scoreboard.
module tb_if_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_ready;

  logic [1:0]  rdy;
  logic [1:0]  ov;
  logic [31:0] opc  [2];
  logic [31:0] oins [2];
  logic [1:0]  occ  [2];

  logic [63:0] sb [2][$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_ctr;

  always #5 clk = ~clk;

  if_id_pipe #(.PC_WIDTH(32), .INST_WIDTH(32), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(ov[0]), .out_ready(out_ready),
    .out_pc(opc[0]), .out_inst(oins[0]), .occupancy(occ[0])
  );

  if_id_pipe #(.PC_WIDTH(32), .INST_WIDTH(32), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(ov[1]), .out_ready(out_ready),
    .out_pc(opc[1]), .out_inst(oins[1]), .occupancy(occ[1])
  );

  // Capacity 1 stage accepts when empty or when decode drains it; skid stage while not full.
  function automatic bit exp_ready(int m, int sz);
    if (!rst) return 1'b0;
    if (m == 1) return sz < 2;
    return (sz == 0) || out_ready;
  endfunction

  task automatic check(string name, int m, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s skid=%0d t=%0t: got %h want %h", name, m, $time, got, want);
    end
  endtask

  // Model update on the active edge.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int  sz;
      bit  inf;
      bit  outf;
      sz   = sb[m].size();
      inf  = in_valid && exp_ready(m, sz);
      outf = (sz != 0) && out_ready;
      if (!rst || flush) begin
        sb[m].delete();
      end else begin
        if (outf) void'(sb[m].pop_front());
        if (inf) sb[m].push_back({in_pc, in_inst});
      end
    end
  end

  // Monitor: compare presented outputs against the scoreboard head away from the edge.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int sz;
      sz = sb[m].size();
      check("in_ready", m, 64'(rdy[m]), 64'(exp_ready(m, sz)));
      check("out_valid", m, 64'(ov[m]), 64'(sz != 0));
      check("occupancy", m, 64'(occ[m]), 64'(sz));
      if (sz != 0) check("out_entry", m, {opc[m], oins[m]}, sb[m][0]);
      else check("nop_entry", m, {opc[m], oins[m]}, 64'd0);
    end
  end

  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy);
    @(posedge clk);
    #1;
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_pc = 32'h400; in_inst = 32'h2401_0400;
    out_ready = 1'b1;
    // Reset held for two edges with fetch offering.
    drive(1'b0, 1'b0, 1'b1, 32'h400, 32'h2401_0400, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    // Streaming.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b0, 1'b1, 32'(i * 4), 32'h2401_0001 + 32'(i), 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    // Skid fill then drain.
    drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h1111_0000, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h104, 32'h1111_0004, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h108, 32'h1111_0008, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h108, 32'h1111_0008, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h108, 32'h1111_0008, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h108, 32'h1111_0008, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    // Flush while full, with a simultaneous offer that must be dropped.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h2222_0000, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h4, 32'h2222_0004, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'h2222_0010, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h2222_0020, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    // Reset while full.
    drive(1'b1, 1'b0, 1'b1, 32'h30, 32'h3333_0030, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h34, 32'h3333_0034, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    // Randomized traffic.
    pc_ctr = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 70), pc_ctr, $urandom(), ($urandom_range(0, 99) < 65));
      pc_ctr = pc_ctr + 32'd4;
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
